// File: rtl/module_mult.sv
// Sequential unsigned shift-and-add multiplier: one multiplier bit per clock,
// WIDTH cycles per product, result and completion flag registered together.
module module_mult #(
  parameter int WIDTH = 8  // operand width, must be >= 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   num_1,
  input  logic [WIDTH-1:0]   num_2,
  input  logic               listo_1,
  input  logic               listo_2,
  output logic [2*WIDTH-1:0] num_mul,
  output logic               listo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state, state_next;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   acc_hi;
  logic [CW-1:0]      count;

  logic               both_ready;
  logic               start;
  logic               last;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] shifted;

  assign both_ready = listo_1 && listo_2;

  // The WIDTH+1-bit sum keeps the carry; it becomes the top bit of the shifted pair.
  assign sum     = {1'b0, acc_hi} + (mplier[0] ? {1'b0, mcand} : '0);
  assign shifted = {sum, mplier[WIDTH-1:1]};

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    start      = 1'b0;
    last       = 1'b0;
    unique case (state)
      IDLE: begin
        if (both_ready) begin
          start      = 1'b1;
          state_next = CALC;
        end
      end
      CALC: begin
        if (count == CW'(WIDTH - 1)) begin
          last       = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        // Holding here while both flags stay high stops the same operands retriggering.
        if (!both_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand   <= '0;
      mplier  <= '0;
      acc_hi  <= '0;
      count   <= '0;
      num_mul <= '0;
      listo   <= 1'b0;
    end else begin
      if (start) begin
        mcand  <= num_1;
        mplier <= num_2;
        acc_hi <= '0;
        count  <= '0;
      end else if (state == CALC) begin
        acc_hi <= shifted[2*WIDTH-1:WIDTH];
        mplier <= shifted[WIDTH-1:0];
        count  <= count + CW'(1);
      end

      // Product and flag update on the same edge, so partial sums are never visible.
      if (last) num_mul <= shifted;
      listo <= (state_next == DONE);
    end
  end

endmodule

// File: tb/tb_module_mult.sv
// Self-checking bench for module_mult: expected products and start edges are
// queued when operands are presented and checked when listo rises.
module tb_module_mult;

  localparam int WIDTH = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic [WIDTH-1:0]   num_1, num_2;
  logic               listo_1, listo_2;
  logic [2*WIDTH-1:0] num_mul;
  logic               listo;

  typedef struct {
    logic [31:0] prod;
    int          start;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   edge_cnt    = 0;
  logic listo_q     = 1'b0;

  module_mult #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .num_1   (num_1),
    .num_2   (num_2),
    .listo_1 (listo_1),
    .listo_2 (listo_2),
    .num_mul (num_mul),
    .listo   (listo)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Scoreboard monitor: every rising listo consumes one expectation.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (listo && !listo_q) begin
      if (sb.size() == 0) begin
        check("spurious_listo", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("product", 32'(num_mul), e.prod);
        check("latency", 32'(edge_cnt - e.start), 32'(WIDTH));
      end
    end
    listo_q = listo;
  end

  task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    exp_t e;
    @(negedge clk);
    num_1   = a;
    num_2   = b;
    listo_1 = 1'b1;
    listo_2 = 1'b1;
    e.prod  = 32'(a) * 32'(b);
    e.start = edge_cnt + 1;
    sb.push_back(e);
  endtask

  task automatic wait_listo(input string tag);
    int n = 0;
    while (!listo && n < 2 * WIDTH + 4) begin
      @(negedge clk);
      n++;
    end
    if (!listo) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  // Called at a negedge: drop both flags, then expect listo low with product held.
  task automatic release_flags(input logic [31:0] exp_mul);
    listo_1 = 1'b0;
    listo_2 = 1'b0;
    @(negedge clk);
    check("release_listo", 32'(listo), 32'd0);
    check("release_hold", 32'(num_mul), exp_mul);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    logic [WIDTH-1:0] a, b;

    rst = 1'b1; listo_1 = 1'b0; listo_2 = 1'b0; num_1 = '0; num_2 = '0;
    @(negedge clk);
    rst = 1'b0;
    check("reset_mul", 32'(num_mul), 32'd0);
    check("reset_listo", 32'(listo), 32'd0);

    // Basic product, flag held while both ready flags stay high.
    start_op(8'd15, 8'd10);
    wait_listo("basic");
    repeat (3) begin
      @(negedge clk);
      check("basic_hold", 32'(listo), 32'd1);
    end
    release_flags(32'd150);

    // Maximum operands exercise the carry bit.
    start_op(8'd255, 8'd255);
    wait_listo("max");
    release_flags(32'd65025);

    // Zero and one operands.
    start_op(8'd0, 8'd200);
    wait_listo("zero");
    release_flags(32'd0);
    start_op(8'd1, 8'd200);
    wait_listo("one");
    release_flags(32'd200);

    // Operands and one flag change mid-computation; result must be unaffected.
    start_op(8'd15, 8'd10);
    repeat (3) @(posedge clk);
    @(negedge clk);
    num_1 = 8'd7; num_2 = 8'd3; listo_1 = 1'b0;
    wait_listo("midcalc");
    @(negedge clk);
    check("midcalc_one_cycle", 32'(listo), 32'd0);
    check("midcalc_hold", 32'(num_mul), 32'd150);
    listo_2 = 1'b0;

    // Flags held long after completion: no retrigger; release then new product.
    start_op(8'd15, 8'd10);
    wait_listo("retrig");
    repeat (20) begin
      @(negedge clk);
      check("retrig_hold", 32'(listo), 32'd1);
    end
    listo_2 = 1'b0;
    @(negedge clk);
    check("drop_listo", 32'(listo), 32'd0);
    check("drop_hold", 32'(num_mul), 32'd150);
    num_1 = 8'd12; num_2 = 8'd12; listo_2 = 1'b1;
    e.prod = 32'd144; e.start = edge_cnt + 1;
    sb.push_back(e);
    wait_listo("restart");
    release_flags(32'd144);

    // Reset mid-computation discards the partial product.
    start_op(8'd255, 8'd255);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    void'(sb.pop_back());
    @(negedge clk);
    check("midreset_mul", 32'(num_mul), 32'd0);
    check("midreset_listo", 32'(listo), 32'd0);
    rst = 1'b0;
    e.prod = 32'd65025; e.start = edge_cnt + 1;
    sb.push_back(e);
    wait_listo("after_reset");
    release_flags(32'd65025);

    // A few random operand pairs.
    for (int i = 0; i < 6; i++) begin
      a = WIDTH'($urandom_range(0, 255));
      b = WIDTH'($urandom_range(0, 255));
      start_op(a, b);
      wait_listo("random");
      release_flags(32'(a) * 32'(b));
    end

    repeat (2) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
